// File: rtl/uart_tx_frame_engine_if.sv
// uart_tx_frame_engine_if
//   Groups the bus-side signals of the UART transmit serialiser into one bundle.
//   The master (control/status register side) drives the registered
//   configuration, the data byte and the start request. The slave (frame
//   engine) drives the serial line and the busy/done/ack status.
//   Signals:
//     Tx_en_r, Two_stop_r, Odd_parity_r : registered configuration
//     tx_start, tx_data                 : start request and byte to send
//     tx_serial                         : serial line, idle high
//     tx_busy, tx_done, tx_ack          : frame status and handshake pulses
interface uart_tx_frame_engine_if #(
  parameter int DATA_BITS = 8
);
  logic                 Tx_en_r;
  logic                 Two_stop_r;
  logic                 Odd_parity_r;
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_serial;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 tx_ack;

  modport master (
    output Tx_en_r, Two_stop_r, Odd_parity_r, tx_start, tx_data,
    input  tx_serial, tx_busy, tx_done, tx_ack
  );

  modport slave (
    input  Tx_en_r, Two_stop_r, Odd_parity_r, tx_start, tx_data,
    output tx_serial, tx_busy, tx_done, tx_ack
  );
endinterface

// File: rtl/uart_tx_frame_engine.sv
// uart_tx_frame_engine
//   Serialises one UART frame per accepted start request: start bit, data bits
//   LSB first, parity bit, then one or two stop bits. Configuration and data
//   are captured at acceptance, so register changes mid-frame do not affect
//   the frame in flight.
//   Ports:
//     clk    : system clock, rising edge
//     reset  : asynchronous active-low reset
//     tx_if  : slave side of uart_tx_frame_engine_if (config, start, data in;
//              tx_serial, tx_busy, tx_done, tx_ack out)
//   Timing: every output is registered from the current state, so the line
//   lags the state by one cycle. tx_ack is high in the cycle after the
//   accepting edge, the line drops low on the next edge, and tx_done follows
//   the last stop bit by the same one-cycle lag, during which a new start is
//   held off. That gap guarantees an idle-high cycle between frames and keeps
//   tx_ack and tx_done apart.
module uart_tx_frame_engine #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input logic                  clk,
  input logic                  reset,
  uart_tx_frame_engine_if.slave tx_if
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t               state;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_r;
  logic                 two_r;
  logic                 baud_last;

  assign baud_last = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      baud_cnt        <= '0;
      bit_idx         <= '0;
      shift           <= '0;
      par_r           <= 1'b0;
      two_r           <= 1'b0;
      tx_if.tx_serial <= 1'b1;
      tx_if.tx_busy   <= 1'b0;
      tx_if.tx_done   <= 1'b0;
      tx_if.tx_ack    <= 1'b0;
    end else begin
      tx_if.tx_ack  <= 1'b0;
      tx_if.tx_done <= 1'b0;
      baud_cnt      <= (state == IDLE || baud_last) ? '0 : baud_cnt + CW'(1);
      case (state)
        IDLE: begin
          tx_if.tx_serial <= 1'b1;
          if (tx_if.tx_busy) begin
            // First IDLE cycle after the last stop bit: report completion.
            tx_if.tx_busy <= 1'b0;
            tx_if.tx_done <= 1'b1;
          end else if (tx_if.Tx_en_r && tx_if.tx_start) begin
            shift         <= tx_if.tx_data;
            // Parity is resolved now so later config writes cannot reach it.
            par_r         <= (^tx_if.tx_data) ^ tx_if.Odd_parity_r;
            two_r         <= tx_if.Two_stop_r;
            bit_idx       <= '0;
            tx_if.tx_busy <= 1'b1;
            tx_if.tx_ack  <= 1'b1;
            state         <= START;
          end
        end
        START: begin
          tx_if.tx_serial <= 1'b0;
          if (baud_last) state <= DATA;
        end
        DATA: begin
          tx_if.tx_serial <= shift[0];
          if (baud_last) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + BW'(1);
            if (bit_idx == BIT_LAST) state <= PARITY;
          end
        end
        PARITY: begin
          tx_if.tx_serial <= par_r;
          if (baud_last) state <= STOP1;
        end
        STOP1: begin
          tx_if.tx_serial <= 1'b1;
          if (baud_last) state <= two_r ? STOP2 : IDLE;
        end
        STOP2: begin
          tx_if.tx_serial <= 1'b1;
          if (baud_last) state <= IDLE;
        end
        default: begin
          tx_if.tx_serial <= 1'b1;
          state           <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// tb_uart_tx_frame_engine
//   Directed bench for uart_tx_frame_engine with CLKS_PER_BIT=4. A frame-level
//   model turns each accepted request into the per-cycle tuple
//   {serial, busy, ack, done} it must produce; one compare process checks the
//   DUT against it every cycle. Directed tasks pin the model with hand-computed
//   bit patterns and frame lengths.
module tb_uart_tx_frame_engine;
  localparam int N = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_tx_frame_engine_if tx_if ();

  uart_tx_frame_engine #(.CLKS_PER_BIT(N), .DATA_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .tx_if (tx_if)
  );

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  // cur = {serial, busy, ack, done} expected during the cycle after an edge.
  logic [3:0] cur = 4'b1000;
  logic [3:0] q[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      cur = 4'b1000;
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else if (tx_if.Tx_en_r && tx_if.tx_start) begin
      logic [7:0] d;
      logic       p;
      logic       b;
      int         nb;
      d   = tx_if.tx_data;
      // parity bit makes total ones odd for odd parity, even for even parity
      p   = (($countones(d) + (tx_if.Odd_parity_r ? 1 : 0)) % 2) == 1;
      nb  = tx_if.Two_stop_r ? 12 : 11;
      cur = 4'b1110;
      for (int k = 0; k < nb; k++) begin
        if (k == 0)      b = 1'b0;
        else if (k <= 8) b = d[k-1];
        else if (k == 9) b = p;
        else             b = 1'b1;
        for (int c = 0; c < N; c++) q.push_back({b, 1'b1, 1'b0, 1'b0});
      end
      q.push_back(4'b1001);
    end else begin
      cur = 4'b1000;
    end
  end

  always @(negedge clk)
    chk("cycle_outputs", {28'd0, tx_if.tx_serial, tx_if.tx_busy, tx_if.tx_ack, tx_if.tx_done},
        {28'd0, cur});

  always @(posedge clk) begin
    if (tx_if.tx_ack === 1'b1)  ack_cnt++;
    if (tx_if.tx_done === 1'b1) done_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] d, input logic odd, input logic two);
    @(negedge clk);
    tx_if.tx_data      = d;
    tx_if.Odd_parity_r = odd;
    tx_if.Two_stop_r   = two;
    tx_if.Tx_en_r      = 1'b1;
    tx_if.tx_start     = 1'b1;
    @(negedge clk);
    tx_if.tx_start     = 1'b0;
  endtask

  // Waits for the start bit, samples each bit mid-period and measures the
  // distance from the first low cycle to tx_done.
  task automatic run_frame(input string name, input logic [11:0] exp_bits, input int nbits,
                           input int exp_len, input bit disturb);
    bit          got;
    int          cyc;
    int          done_at;
    logic [11:0] bits;
    logic [11:0] mask;
    bit          busy_drop;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (tx_if.tx_serial === 1'b0) got = 1'b1;
    end
    chk({name, "_start_seen"}, {31'd0, got}, 32'd1);
    cyc = 0; done_at = -1; bits = '0; mask = '0; busy_drop = 1'b0;
    for (int i = 0; i < nbits; i++) mask[i] = 1'b1;
    while (got && done_at < 0 && cyc < 200) begin
      if ((cyc % N) == 1 && (cyc / N) < nbits) bits[cyc / N] = tx_if.tx_serial;
      if (tx_if.tx_done === 1'b1) done_at = cyc;
      else if (tx_if.tx_busy !== 1'b1) busy_drop = 1'b1;
      if (disturb) begin
        if (cyc == 8)  begin tx_if.Odd_parity_r = 1'b1; tx_if.Two_stop_r = 1'b1;
                             tx_if.Tx_en_r = 1'b0; tx_if.tx_start = 1'b1; end
        if (cyc == 9)  tx_if.tx_start = 1'b0;
        if (cyc == 20) begin tx_if.Tx_en_r = 1'b1; tx_if.tx_start = 1'b1; end
        if (cyc == 21) tx_if.tx_start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    chk({name, "_bits"}, {20'd0, bits & mask}, {20'd0, exp_bits & mask});
    chk({name, "_len"}, done_at, exp_len);
    chk({name, "_busy_held"}, {31'd0, busy_drop}, 32'd0);
  endtask

  initial begin
    int a0;
    int d0;
    bit ok;
    tx_if.Tx_en_r      = 1'b0;
    tx_if.Two_stop_r   = 1'b0;
    tx_if.Odd_parity_r = 1'b0;
    tx_if.tx_start     = 1'b0;
    tx_if.tx_data      = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_state", {28'd0, tx_if.tx_serial, tx_if.tx_busy, tx_if.tx_ack, tx_if.tx_done}, 32'h8);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5, even parity, one stop: 0,1,0,1,0,0,1,0,1,0,1
    a0 = ack_cnt;
    send(8'hA5, 1'b0, 1'b0);
    run_frame("a5_even_1stop", 12'h54A, 11, 44, 1'b0);
    repeat (2) @(negedge clk);
    chk("a5_even_ack_once", ack_cnt - a0, 1);

    // 0xA5, odd parity, two stops: parity 1, frame 48
    send(8'hA5, 1'b1, 1'b1);
    run_frame("a5_odd_2stop", 12'hF4A, 12, 48, 1'b0);
    repeat (2) @(negedge clk);

    // Disabled transmitter ignores a held start
    a0 = ack_cnt; ok = 1'b1;
    @(negedge clk);
    tx_if.Tx_en_r = 1'b0; tx_if.Odd_parity_r = 1'b0; tx_if.Two_stop_r = 1'b0;
    tx_if.tx_start = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (tx_if.tx_serial !== 1'b1 || tx_if.tx_busy !== 1'b0) ok = 1'b0;
    end
    tx_if.tx_start = 1'b0;
    @(negedge clk);
    chk("disabled_no_ack", ack_cnt - a0, 0);
    chk("disabled_line_idle", {31'd0, ok}, 32'd1);

    // 0x3C with config churn mid-frame: latched even/one-stop frame
    a0 = ack_cnt; d0 = done_cnt;
    send(8'h3C, 1'b0, 1'b0);
    run_frame("3c_latched_cfg", 12'h478, 11, 44, 1'b1);
    tx_if.Odd_parity_r = 1'b0; tx_if.Two_stop_r = 1'b0; tx_if.Tx_en_r = 1'b1;
    repeat (4) @(negedge clk);
    chk("3c_one_ack", ack_cnt - a0, 1);
    chk("3c_one_done", done_cnt - d0, 1);

    // Held start: back-to-back frames, one ack and one done each
    a0 = ack_cnt; d0 = done_cnt;
    @(negedge clk);
    tx_if.tx_data = 8'h55; tx_if.Tx_en_r = 1'b1; tx_if.tx_start = 1'b1;
    for (int i = 0; i < 400 && (ack_cnt - a0) < 3; i++) @(negedge clk);
    tx_if.tx_start = 1'b0;
    for (int i = 0; i < 200 && (done_cnt - d0) < 3; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("b2b_acks", ack_cnt - a0, 3);
    chk("b2b_dones", done_cnt - d0, 3);

    // Asynchronous reset in the middle of DATA, then a clean 0xFF frame
    send(8'h5A, 1'b0, 1'b0);
    repeat (12) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_serial", {31'd0, tx_if.tx_serial}, 32'd1);
    chk("async_reset_busy", {31'd0, tx_if.tx_busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    send(8'hFF, 1'b0, 1'b0);
    run_frame("ff_after_reset", 12'h5FE, 11, 44, 1'b0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
